// File: rtl/bcd_interval_sequencer_pkg.sv
// bcd_interval_sequencer_pkg: shared state encoding and BCD constants
package bcd_interval_sequencer_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    typedef enum logic [2:0] {CLEAR, IDLE, LOAD, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/bcd_digit_complement.sv
// bcd_digit_complement: nine's complement of one BCD digit plus digit validity
module bcd_digit_complement
    import bcd_interval_sequencer_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] comp,
    output logic               valid
);
    assign valid = digit <= BCD_MAX;
    assign comp  = BCD_MAX - digit;
endmodule

// File: rtl/bcd_interval_sequencer.sv
// bcd_interval_sequencer: drives a 74162 decade chain from 9's-complement preset up to all-9s
module bcd_interval_sequencer
    import bcd_interval_sequencer_pkg::*;
#(
    parameter int DIGITS     = 2,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      Pause,
    input  logic                      Abort,
    input  logic [DIGIT_W*DIGITS-1:0] Preset,
    input  logic                      Chain_RCO,
    output logic                      Clear_bar,
    output logic                      Load_bar,
    output logic                      ENT,
    output logic                      ENP,
    output logic [DIGIT_W*DIGITS-1:0] D,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Error
);
    state_t                      state, state_nxt;
    logic [DIGIT_W*DIGITS-1:0]   comp;
    logic [DIGITS-1:0]           valid;
    logic                        preset_ok, start_ok, start_bad;

    // Output delays are simulation annotations only; registered outputs carry no delay here.
    if (DIGITS < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_complement u_comp (
            .digit(Preset[i*DIGIT_W +: DIGIT_W]),
            .comp (comp[i*DIGIT_W +: DIGIT_W]),
            .valid(valid[i])
        );
    end

    assign preset_ok = &valid;
    assign start_ok  = Start & preset_ok;
    assign start_bad = Start & ~preset_ok & ((state == IDLE) | ((state == DONE) & ~Abort));
    // Gating on RCO stops the chain at all-9s without wrapping.
    assign ENP       = (state == RUN) & ~Chain_RCO;

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   state_nxt = IDLE;
            IDLE:    state_nxt = start_ok ? LOAD : IDLE;
            LOAD:    state_nxt = Abort ? CLEAR : RUN;
            RUN:     state_nxt = Abort ? CLEAR : Chain_RCO ? DONE : Pause ? PAUSE : RUN;
            PAUSE:   state_nxt = Abort ? CLEAR : Pause ? PAUSE : RUN;
            DONE:    state_nxt = Abort ? CLEAR : start_ok ? LOAD : DONE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= CLEAR;
            Clear_bar <= 1'b0;
            Load_bar  <= 1'b1;
            ENT       <= 1'b0;
            D         <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            Clear_bar <= state_nxt != CLEAR;
            Load_bar  <= state_nxt != LOAD;
            ENT       <= state_nxt inside {LOAD, RUN, PAUSE, DONE};
            Busy      <= state_nxt inside {LOAD, RUN, PAUSE};
            Done      <= state_nxt == DONE;
            Error     <= start_bad;
            if (state_nxt == LOAD)
                D <= comp;
        end
    end
endmodule

// File: tb/tb_bcd_interval_sequencer.sv
// tb_bcd_interval_sequencer: scoreboard bench with a decimal chain plant and interval model
module tb_bcd_interval_sequencer;
    logic       Clk = 0, Reset = 1, Start = 0, Pause = 0, Abort = 0;
    logic [7:0] Preset = 8'h00;
    logic       Chain_RCO, Clear_bar, Load_bar, ENT, ENP, Busy, Done, Error;
    logic [7:0] D;
    int         cyc = 0, q = 37, checks = 0, failures = 0;
    int         exp_load_cyc[$], exp_done[$], exp_err[$];
    logic [7:0] exp_load_d[$];
    logic       done_prev = 0;

    bcd_interval_sequencer #(.DIGITS(2), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Pause(Pause), .Abort(Abort),
        .Preset(Preset), .Chain_RCO(Chain_RCO), .Clear_bar(Clear_bar),
        .Load_bar(Load_bar), .ENT(ENT), .ENP(ENP), .D(D),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Two-digit decade chain seen as one decimal counter (synchronous clear/load like the 74162).
    assign Chain_RCO = ENT && q == 99;
    always @(posedge Clk) begin
        if (!Clear_bar) q <= 0;
        else if (!Load_bar) q <= from_bcd(D);
        else if (ENT && ENP) q <= (q + 1) % 100;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (!Load_bar) begin
                chk("load_pending", exp_load_cyc.size() > 0, 1);
                if (exp_load_cyc.size() > 0) begin
                    chk("load_cycle", cyc, exp_load_cyc.pop_front());
                    chk("load_d", D, exp_load_d.pop_front());
                end
            end
            if (Done && !done_prev) begin
                chk("done_pending", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) chk("done_cycle", cyc, exp_done.pop_front());
                chk("done_q", q, 99);
            end
            if (Error) begin
                chk("error_pending", exp_err.size() > 0, 1);
                if (exp_err.size() > 0) chk("error_cycle", cyc, exp_err.pop_front());
            end
        end
        done_prev <= Done;
    end

    task automatic issue(input logic [7:0] pre, input int ps, input int pn, output bit ok, output int k);
        logic was_done;
        ok = pre[7:4] <= 9 && pre[3:0] <= 9;
        k = cyc + 1;
        was_done = Done;
        Preset = pre;
        Start = 1;
        if (ok) begin
            exp_load_cyc.push_back(k);
            exp_load_d.push_back(to_bcd(99 - from_bcd(pre)));
            exp_done.push_back(k + from_bcd(pre) + 2 + pn);
        end else
            exp_err.push_back(k);
        @(negedge Clk);
        Start = 0;
        Preset = 8'($urandom);
        chk("busy_after_start", Busy, ok);
        chk("done_after_start", Done, ok ? 1'b0 : was_done);
        if (ok && pn > 0) begin
            while (cyc < k + ps - 1) @(negedge Clk);
            Pause = 1;
            repeat (pn) @(negedge Clk);
            Pause = 0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!Done && n < 400) begin
            @(negedge Clk);
            n++;
        end
        chk("done_reached", Done, 1);
        repeat (2) @(negedge Clk);
        chk("hold_q", q, 99);
        chk("hold_enp", ENP, 0);
    endtask

    task automatic trial(input logic [7:0] pre, input int ps, input int pn);
        bit ok;
        int k;
        issue(pre, ps, pn, ok, k);
        if (ok) wait_done();
        else begin
            @(negedge Clk);
            chk("error_one_cycle", Error, 0);
            chk("load_bar_held", Load_bar, 1);
        end
    endtask

    task automatic abort_pulse();
        Abort = 1;
        @(negedge Clk);
        Abort = 0;
        chk("abort_clear_bar", Clear_bar, 0);
        chk("abort_done", Done, 0);
        @(negedge Clk);
        chk("abort_idle", Clear_bar, 1);
        chk("abort_q", q, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pre;
        int p, ps, pn, k, n;
        bit ok;
        repeat (3) @(negedge Clk);
        chk("rst_clear_bar", Clear_bar, 0);
        chk("rst_load_bar", Load_bar, 1);
        chk("rst_ent", ENT, 0);
        chk("rst_enp", ENP, 0);
        chk("rst_d", D, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_error", Error, 0);
        chk("rst_q", q, 0);
        Reset = 0;
        chk("clear_cycle", Clear_bar, 0);
        @(negedge Clk);
        chk("idle_clear_bar", Clear_bar, 1);
        chk("idle_busy", Busy, 0);
        Abort = 1;
        @(negedge Clk);
        Abort = 0;
        chk("abort_in_idle", Clear_bar, 1);

        trial(8'h25, 0, 0);
        trial(8'h00, 0, 0);
        abort_pulse();
        trial(8'h3A, 0, 0);
        trial(8'h10, 5, 5);
        trial(8'h07, 0, 0);
        trial(8'hF1, 0, 0);

        // Abort and Pause together mid-count: abort wins.
        issue(8'h25, 0, 0, ok, k);
        n = 0;
        while (q != 95 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("reach_95", q, 95);
        Abort = 1;
        Pause = 1;
        @(negedge Clk);
        Abort = 0;
        Pause = 0;
        exp_done.delete();
        chk("abort_run_clear", Clear_bar, 0);
        chk("abort_run_busy", Busy, 0);
        @(negedge Clk);
        chk("abort_run_q", q, 0);
        chk("abort_run_idle", Clear_bar, 1);

        for (int t = 0; t < 24; t++) begin
            pre = to_bcd($urandom_range(0, 99));
            if ($urandom_range(0, 4) == 0) pre[4 * $urandom_range(0, 1) +: 4] = 4'($urandom_range(10, 15));
            p = from_bcd(pre);
            pn = 0;
            ps = 0;
            if (pre[7:4] <= 9 && pre[3:0] <= 9 && p >= 1 && $urandom_range(0, 1) == 1) begin
                ps = $urandom_range(2, p + 1);
                pn = $urandom_range(1, 6);
            end
            trial(pre, ps, pn);
            if (t % 6 == 5 && Done) abort_pulse();
        end

        // Asynchronous reset in the middle of a count.
        issue(8'h50, 0, 0, ok, k);
        repeat (10) @(negedge Clk);
        #2 Reset = 1;
        #1;
        chk("midrst_d", D, 0);
        chk("midrst_clear_bar", Clear_bar, 0);
        chk("midrst_busy", Busy, 0);
        exp_done.delete();
        @(negedge Clk);
        Reset = 0;
        @(negedge Clk);
        chk("midrst_idle", Clear_bar, 1);
        chk("midrst_q", q, 0);
        chk("queues_drained", exp_load_cyc.size() + exp_done.size() + exp_err.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
